pc_seq_ctrl: RTL and testbench

- Multi-cycle sequencing FSM for the CPU's PC datapath.
- Drives write enables for PC, TempPC and IR; selects the next-PC source; sequences data-memory and multiply/divide waits; counts retired instructions.
- Sits between the instruction decoder and the PC/TempPC/IR/regfile/memory datapath.

---
 rtl/pc_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - multi-cycle sequencing FSM for the PC/TempPC/IR datapath
module pc_seq_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic [2:0]       op_class,
  input  logic             br_taken,
  input  logic             mdu_done,
  output logic             ir_we,
  output logic             temppc_we,
  output logic             pc_we,
  output logic [2:0]       pc_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             mdu_start,
  output logic             exc_req,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_MDU  = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;
  localparam logic [2:0] OP_JR     = 3'd5;
  localparam logic [2:0] OP_MULDIV = 3'd6;
  localparam logic [2:0] OP_EXC    = 3'd7;

  localparam logic [2:0] SEL_PC4 = 3'd0;
  localparam logic [2:0] SEL_BR  = 3'd1;
  localparam logic [2:0] SEL_J   = 3'd2;
  localparam logic [2:0] SEL_RS  = 3'd3;
  localparam logic [2:0] SEL_EXC = 3'd4;

  localparam int         TW      = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MDU_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [TW-1:0]    to_cnt;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic ir_we_c, temppc_we_c, pc_we_c, dmem_req_c, dmem_we_c, rf_we_c, mdu_start_c, exc_req_c;
  logic [2:0] pc_sel_c;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    ir_we_c     = 1'b0;
    temppc_we_c = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = SEL_PC4;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    rf_we_c     = 1'b0;
    mdu_start_c = 1'b0;
    exc_req_c   = 1'b0;
    case (state_q)
      S_IF: begin
        if (!run) begin
          state_d = S_HALT;
        end else if (imem_ready) begin
          ir_we_c     = 1'b1;
          temppc_we_c = 1'b1;
          pc_we_c     = 1'b1;
          state_d     = S_ID;
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        case (op_q)
          OP_ALU:            state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            if (br_taken) begin
              pc_we_c  = 1'b1;
              pc_sel_c = SEL_BR;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end
          OP_JUMP, OP_JR: begin
            pc_we_c  = 1'b1;
            pc_sel_c = (op_q == OP_JUMP) ? SEL_J : SEL_RS;
            rf_we_c  = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
          end
          OP_MULDIV: begin
            mdu_start_c = 1'b1;
            state_d     = S_MDU;
          end
          default: begin
            exc_req_c = 1'b1;
            pc_we_c   = 1'b1;
            pc_sel_c  = SEL_EXC;
            state_d   = S_IF;
          end
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (op_q == OP_STORE);
        if (dmem_ready) begin
          retire  = (op_q == OP_STORE);
          state_d = (op_q == OP_STORE) ? S_IF : S_WB;
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_MDU: begin
        // A late mdu_done on the final allowed cycle still counts as success.
        if (mdu_done) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else if (to_cnt == TO_LAST) begin
          exc_req_c = 1'b1;
          pc_we_c   = 1'b1;
          pc_sel_c  = SEL_EXC;
          state_d   = S_IF;
        end
      end
      S_HALT: begin
        if (run) state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      op_q    <= OP_ALU;
      to_cnt  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= op_class;
      if (state_q == S_EX && op_q == OP_MULDIV) to_cnt <= '0;
      else if (state_q == S_MDU) to_cnt <= to_cnt + TW'(1);
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // Strobes are masked by reset directly so none outlives an abort.
  assign ir_we       = ir_we_c & reset;
  assign temppc_we   = temppc_we_c & reset;
  assign pc_we       = pc_we_c & reset;
  assign pc_sel      = reset ? pc_sel_c : SEL_PC4;
  assign dmem_req    = dmem_req_c & reset;
  assign dmem_we     = dmem_we_c & reset;
  assign rf_we       = rf_we_c & reset;
  assign mdu_start   = mdu_start_c & reset;
  assign exc_req     = exc_req_c & reset;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - scoreboard bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset, run, imem_ready, dmem_ready, br_taken, mdu_done;
  logic [2:0] op_class;
  logic ir_we, temppc_we, pc_we, dmem_req, dmem_we, rf_we, mdu_start, exc_req;
  logic [2:0] pc_sel, state;
  logic [31:0] instr_count;
  logic s_ir_we, s_temppc_we, s_pc_we, s_dmem_req, s_dmem_we, s_rf_we, s_mdu_start, s_exc_req;
  logic [2:0] s_pc_sel, s_state;
  logic [2:0] s_instr_count;

  always #5 clk = ~clk;

  pc_seq_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .op_class(op_class), .br_taken(br_taken), .mdu_done(mdu_done),
    .ir_we(ir_we), .temppc_we(temppc_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .mdu_start(mdu_start),
    .exc_req(exc_req), .state(state), .instr_count(instr_count)
  );

  pc_seq_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .op_class(op_class), .br_taken(br_taken), .mdu_done(mdu_done),
    .ir_we(s_ir_we), .temppc_we(s_temppc_we), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .rf_we(s_rf_we), .mdu_start(s_mdu_start),
    .exc_req(s_exc_req), .state(s_state), .instr_count(s_instr_count)
  );

  typedef struct {
    string      tag;
    logic       run, imr, dmr, br, md;
    logic [2:0] op, st, sel;
    logic [7:0] stb;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t sbq[$];
  logic [31:0] exp_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(string tag, logic [2:0] st, logic rn, logic imr, logic dmr,
                               logic br, logic md, logic [2:0] op, logic [2:0] sel,
                               logic [7:0] stb, bit retire);
    cyc_t c;
    c.tag = tag; c.st = st; c.run = rn; c.imr = imr; c.dmr = dmr; c.br = br; c.md = md;
    c.op = op; c.sel = sel; c.stb = stb; c.cnt = exp_cnt;
    sbq.push_back(c);
    if (retire) exp_cnt = exp_cnt + 32'd1;
  endfunction

  // Strobe byte: {ir_we, temppc_we, pc_we, dmem_req, dmem_we, rf_we, mdu_start, exc_req}
  function automatic void add_instr(string tag, logic [2:0] op, int waits, int lat, logic br, logic run_ex);
    logic [2:0] rop;
    rop = 3'($urandom_range(0, 7));
    for (int i = 0; i < waits; i++) push({tag, "/ifw"}, 3'd0, 1'b1, 1'b0, r1(), r1(), r1(), rop, 3'd0, 8'h00, 0);
    push({tag, "/if"}, 3'd0, 1'b1, 1'b1, r1(), r1(), r1(), rop, 3'd0, 8'hE0, 0);
    push({tag, "/id"}, 3'd1, r1(), r1(), r1(), r1(), r1(), op, 3'd0, 8'h00, 0);
    case (op)
      3'd0: begin
        push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), r1(), r1(), rop, 3'd0, 8'h00, 0);
        push({tag, "/wb"}, 3'd4, r1(), r1(), r1(), r1(), r1(), rop, 3'd0, 8'h04, 1);
      end
      3'd1, 3'd2: begin
        push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), r1(), r1(), rop, 3'd0, 8'h00, 0);
        for (int i = 0; i < lat; i++)
          push({tag, "/memw"}, 3'd3, r1(), r1(), 1'b0, r1(), r1(), rop, 3'd0, (op == 3'd2) ? 8'h18 : 8'h10, 0);
        push({tag, "/mem"}, 3'd3, r1(), r1(), 1'b1, r1(), r1(), rop, 3'd0, (op == 3'd2) ? 8'h18 : 8'h10, op == 3'd2);
        if (op == 3'd1) push({tag, "/wb"}, 3'd4, r1(), r1(), r1(), r1(), r1(), rop, 3'd0, 8'h04, 1);
      end
      3'd3: push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), br, r1(), rop, br ? 3'd1 : 3'd0, br ? 8'h20 : 8'h00, 1);
      3'd4: push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), r1(), r1(), rop, 3'd2, 8'h24, 1);
      3'd5: push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), r1(), r1(), rop, 3'd3, 8'h24, 1);
      3'd6: begin
        push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), r1(), r1(), rop, 3'd0, 8'h02, 0);
        if (lat > 0) begin
          for (int i = 0; i < lat - 1; i++)
            push({tag, "/mdu"}, 3'd5, r1(), r1(), r1(), r1(), 1'b0, rop, 3'd0, 8'h00, 0);
          push({tag, "/done"}, 3'd5, r1(), r1(), r1(), r1(), 1'b1, rop, 3'd0, 8'h00, 1);
        end else begin
          for (int i = 0; i < TO - 1; i++)
            push({tag, "/mdu"}, 3'd5, r1(), r1(), r1(), r1(), 1'b0, rop, 3'd0, 8'h00, 0);
          push({tag, "/tmo"}, 3'd5, r1(), r1(), r1(), r1(), 1'b0, rop, 3'd4, 8'h21, 0);
        end
      end
      default: push({tag, "/ex"}, 3'd2, run_ex, r1(), r1(), r1(), r1(), rop, 3'd4, 8'h21, 0);
    endcase
  endfunction

  task automatic drain();
    cyc_t c;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      run = c.run; imem_ready = c.imr; dmem_ready = c.dmr; br_taken = c.br;
      mdu_done = c.md; op_class = c.op;
      @(negedge clk);
      check_eq({c.tag, "/state"}, 64'(state), 64'(c.st));
      check_eq({c.tag, "/pc_sel"}, 64'(pc_sel), 64'(c.sel));
      check_eq({c.tag, "/strobes"},
               64'({ir_we, temppc_we, pc_we, dmem_req, dmem_we, rf_we, mdu_start, exc_req}), 64'(c.stb));
      check_eq({c.tag, "/count"}, 64'(instr_count), 64'(c.cnt));
      check_eq({c.tag, "/count3"}, 64'(s_instr_count), 64'(c.cnt[2:0]));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_cnt = 32'd0;
    reset = 1'b0; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    br_taken = 1'b1; mdu_done = 1'b1; op_class = 3'd0;
    #3;
    check_eq("rst/state", 64'(state), 64'd0);
    check_eq("rst/count", 64'(instr_count), 64'd0);
    check_eq("rst/strobes",
             64'({ir_we, temppc_we, pc_we, dmem_req, dmem_we, rf_we, mdu_start, exc_req}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/hold_state", 64'(state), 64'd0);
    imem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    add_instr("alu", 3'd0, 1, 0, 1'b0, 1'b1);
    add_instr("load", 3'd1, 0, 3, 1'b0, 1'b1);
    add_instr("store", 3'd2, 0, 3, 1'b0, 1'b1);
    add_instr("br_t", 3'd3, 0, 0, 1'b1, 1'b1);
    add_instr("br_nt", 3'd3, 0, 0, 1'b0, 1'b1);
    add_instr("jump", 3'd4, 0, 0, 1'b0, 1'b1);
    add_instr("exc", 3'd7, 0, 0, 1'b0, 1'b1);
    add_instr("mdu", 3'd6, 0, 10, 1'b0, 1'b1);
    add_instr("mdu_to", 3'd6, 0, 0, 1'b0, 1'b1);
    add_instr("jr_stop", 3'd5, 0, 0, 1'b0, 1'b0);
    push("stop/if", 3'd0, 1'b0, 1'b1, r1(), r1(), r1(), 3'd0, 3'd0, 8'h00, 0);
    push("halt0", 3'd6, 1'b0, 1'b1, r1(), r1(), r1(), 3'd0, 3'd0, 8'h00, 0);
    push("halt1", 3'd6, 1'b0, 1'b1, r1(), r1(), r1(), 3'd0, 3'd0, 8'h00, 0);
    push("halt_go", 3'd6, 1'b1, 1'b0, r1(), r1(), r1(), 3'd0, 3'd0, 8'h00, 0);
    add_instr("alu2", 3'd0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] rop;
      rop = 3'($urandom_range(0, 7));
      add_instr($sformatf("rnd%0d", i), rop, $urandom_range(0, 2),
                (rop == 3'd6) ? $urandom_range(1, 5) : $urandom_range(0, 2), r1(), r1());
    end
    push("ld2/if", 3'd0, 1'b1, 1'b1, 1'b0, r1(), r1(), 3'd0, 3'd0, 8'hE0, 0);
    push("ld2/id", 3'd1, 1'b1, 1'b0, 1'b0, r1(), r1(), 3'd1, 3'd0, 8'h00, 0);
    push("ld2/ex", 3'd2, 1'b1, 1'b0, 1'b0, r1(), r1(), 3'd0, 3'd0, 8'h00, 0);
    push("ld2/mem", 3'd3, 1'b1, 1'b0, 1'b0, r1(), r1(), 3'd0, 3'd0, 8'h10, 0);
    drain();

    dmem_ready = 1'b0;
    @(negedge clk);
    check_eq("pre_rst/state", 64'(state), 64'd3);
    check_eq("pre_rst/dmem_req", 64'(dmem_req), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst/state", 64'(state), 64'd0);
    check_eq("mid_rst/dmem_req", 64'(dmem_req), 64'd0);
    check_eq("mid_rst/count", 64'(instr_count), 64'd0);
    @(posedge clk);
    #1;
    check_eq("mid_rst/strobes",
             64'({ir_we, temppc_we, pc_we, dmem_req, dmem_we, rf_we, mdu_start, exc_req}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
